// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: combinational hit path, one-line
// refill over a single-word-per-beat memory port, whole-cache invalidate.
module icache_direct_mapped #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] cache_address_i,
  output logic [29:0] cache_instr_o,
  output logic        cache_blocking_n_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [29:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  // state  | meaning
  // IDLE   | lookup; hit served combinationally, miss launches a refill
  // REFILL | fetching the latched line from memory, one word per ack
  // DONE   | single bubble before the lookup resumes

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int LA_W  = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [29:0]          r_data [NUM_LINES*LINE_WORDS];
  logic [LA_W-1:0]      r_line_addr;
  logic [OFF_W-1:0]     r_beat;
  logic                 r_mem_req;
  logic                 r_flush_pend;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_line_idx;
  logic [TAG_W-1:0] w_line_tag;
  logic             w_hit;
  logic             w_miss;
  logic             w_beat_ack;
  logic             w_last_beat;
  logic             w_unused;

  assign w_off       = cache_address_i[OFF_W-1:0];
  assign w_idx       = cache_address_i[OFF_W +: IDX_W];
  assign w_tag       = cache_address_i[29 -: TAG_W];
  assign w_line_idx  = r_line_addr[IDX_W-1:0];
  assign w_line_tag  = r_line_addr[LA_W-1:IDX_W];
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_ack  = (r_state == S_REFILL) & mem_ack_i;

  assign w_hit  = r_valid[w_idx] & (r_tag[w_idx] == w_tag) & (r_state == S_IDLE);
  assign w_miss = (r_state == S_IDLE) & ~w_hit & ~flush_i;

  // Low two bits of an instruction word are never stored.
  assign w_unused = ^mem_data_i[1:0];

  assign cache_blocking_n_o = w_hit & ~flush_i;
  assign cache_instr_o      = r_data[{w_idx, w_off}];
  assign mem_req_o          = r_mem_req;
  assign mem_addr_o         = {r_line_addr, r_beat};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_line_addr  <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_line_addr <= {w_tag, w_idx};
            r_beat      <= '0;
            r_mem_req   <= 1'b1;
            r_state     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (mem_ack_i) begin
            if (w_last_beat) begin
              r_mem_req <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_beat <= r_beat + OFF_W'(1);
            end
          end
        end
        S_DONE: begin
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush on the final-ack edge wins: the line is left invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid <= '0;
    end else if (w_beat_ack && w_last_beat && !r_flush_pend) begin
      r_valid[w_line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_beat_ack && !rst_i) begin
      r_data[{w_line_idx, r_beat}] <= mem_data_i[31:2];
      if (w_last_beat) r_tag[w_line_idx] <= w_line_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed scenarios then random fetches,
// checked against a line-ownership model of the cache and a memory function.
module tb_icache_direct_mapped;
  localparam int NL = 64;
  localparam int LW = 4;
  localparam int EV_NONE  = 0;
  localparam int EV_FLUSH = 1;
  localparam int EV_REDIR = 2;
  localparam int EV_RST   = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [29:0] cache_address_i;
  logic [29:0] cache_instr_o;
  logic        cache_blocking_n_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which memory line (word address / LW) each index currently holds.
  bit          m_valid [NL];
  int unsigned m_line  [NL];

  always #5 clk_i = ~clk_i;

  icache_direct_mapped #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cache_address_i    (cache_address_i),
    .cache_instr_o      (cache_instr_o),
    .cache_blocking_n_o (cache_blocking_n_o),
    .flush_i            (flush_i),
    .mem_req_o          (mem_req_o),
    .mem_addr_o         (mem_addr_o),
    .mem_ack_i          (mem_ack_i),
    .mem_data_i         (mem_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    case (a)
      30'h40:  return 32'h0000_0013;
      30'h41:  return 32'h0010_0093;
      30'h42:  return 32'h0020_0113;
      30'h43:  return 32'h0030_0193;
      default: return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic do_flush_idle(input logic [29:0] a);
    cache_address_i = a;
    flush_i = 1'b1;
    #1;
    chk("flush_blk", cache_blocking_n_o, 1'b0);
    chk("flush_req", mem_req_o, 1'b0);
    tick();
    flush_i = 1'b0;
    model_clear();
  endtask

  // One fetch; on a miss, serves the whole refill with wmin..wmax wait cycles
  // per beat and optionally injects a flush, redirect or reset at ev_beat.
  task automatic do_access(input logic [29:0] a, input int wmin, input int wmax,
                           input int ev, input int ev_beat, input logic [29:0] redir);
    int          idx;
    int          stall;
    int          waits;
    int          w;
    bit          hit;
    bit          flushed;
    logic [29:0] base;
    idx  = int'((a >> 2) % NL);
    base = {a[29:2], 2'b00};
    cache_address_i = a;
    flush_i    = 1'b0;
    mem_ack_i  = 1'($urandom);
    mem_data_i = $urandom;
    #1;
    hit = m_valid[idx] && (m_line[idx] == 32'(a >> 2));
    chk("lookup_blk", cache_blocking_n_o, hit);
    chk("idle_req", mem_req_o, 1'b0);
    if (hit) begin
      chk("hit_instr", cache_instr_o, mem_fn(a) >> 2);
      tick();
      mem_ack_i = 1'b0;
      return;
    end
    stall   = (cache_blocking_n_o === 1'b0) ? 1 : 0;
    waits   = 0;
    flushed = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    for (int b = 0; b < LW; b++) begin
      if (ev == EV_REDIR && b == ev_beat) cache_address_i = redir;
      w = int'($urandom_range(wmax, wmin));
      waits += w;
      for (int k = 0; k <= w; k++) begin
        if (k == 0 && b == ev_beat && ev == EV_FLUSH) begin
          flush_i = 1'b1;
          flushed = 1'b1;
        end
        if (k == 0 && b == ev_beat && ev == EV_RST) rst_i = 1'b1;
        mem_ack_i  = (k == w);
        mem_data_i = (k == w) ? mem_fn(base + 30'(b)) : $urandom;
        #1;
        chk("refill_req", mem_req_o, 1'b1);
        chk("refill_addr", mem_addr_o, base + 30'(b));
        chk("refill_blk", cache_blocking_n_o, 1'b0);
        if (cache_blocking_n_o === 1'b0) stall++;
        tick();
        flush_i   = 1'b0;
        mem_ack_i = 1'b0;
        if (rst_i) begin
          rst_i = 1'b0;
          #1;
          chk("rst_req", mem_req_o, 1'b0);
          chk("rst_addr", mem_addr_o, 30'h0);
          chk("rst_blk", cache_blocking_n_o, 1'b0);
          model_clear();
          return;
        end
      end
    end
    if (flushed) model_clear();
    mem_ack_i  = 1'($urandom);
    mem_data_i = $urandom;
    #1;
    chk("done_req", mem_req_o, 1'b0);
    chk("done_blk", cache_blocking_n_o, 1'b0);
    if (cache_blocking_n_o === 1'b0) stall++;
    tick();
    mem_ack_i = 1'b0;
    if (!flushed) begin
      m_valid[idx] = 1'b1;
      m_line[idx]  = 32'(a >> 2);
    end
    chk("miss_penalty", stall, LW + waits + 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          r;
    logic [29:0] a;
    logic [29:0] ra;
    rst_i = 1'b1;
    flush_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    cache_address_i = 30'h40;
    model_clear();
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    chk("reset_req", mem_req_o, 1'b0);
    chk("reset_addr", mem_addr_o, 30'h0);
    chk("reset_blk", cache_blocking_n_o, 1'b0);

    // First miss and sequential hits within the line.
    do_access(30'h40, 0, 0, EV_NONE, -1, 30'h0);
    for (int i = 0; i < 4; i++) do_access(30'h40 + 30'(i), 0, 0, EV_NONE, -1, 30'h0);

    // Conflict on index 16.
    do_access(30'h440, 0, 0, EV_NONE, -1, 30'h0);
    do_access(30'h40, 0, 0, EV_NONE, -1, 30'h0);

    // Memory wait states: ack every third cycle.
    do_access(30'h442, 2, 2, EV_NONE, -1, 30'h0);
    do_access(30'h443, 0, 0, EV_NONE, -1, 30'h0);

    // Redirect during beat 1; latched line still completes.
    do_access(30'h40, 0, 1, EV_REDIR, 1, 30'h80);
    do_access(30'h80, 0, 0, EV_NONE, -1, 30'h0);
    do_access(30'h41, 0, 0, EV_NONE, -1, 30'h0);

    // Flush in IDLE, then during beat 2, then on the final ack.
    do_flush_idle(30'h40);
    do_access(30'h40, 0, 0, EV_NONE, -1, 30'h0);
    do_access(30'h44, 0, 0, EV_FLUSH, 2, 30'h0);
    do_access(30'h44, 0, 0, EV_NONE, -1, 30'h0);
    do_access(30'h48, 0, 0, EV_FLUSH, 3, 30'h0);
    do_access(30'h48, 1, 2, EV_NONE, -1, 30'h0);

    // Reset on beat 2, then refetch restarts from beat 0.
    do_access(30'h40, 0, 0, EV_RST, 2, 30'h0);
    do_access(30'h40, 0, 0, EV_NONE, -1, 30'h0);
    do_access(30'h43, 0, 0, EV_NONE, -1, 30'h0);

    for (int n = 0; n < 400; n++) begin
      a  = (30'($urandom_range(2, 0)) << 8) | (30'($urandom_range(7, 0)) << 2)
         | 30'($urandom_range(3, 0));
      ra = (30'($urandom_range(2, 0)) << 8) | (30'($urandom_range(7, 0)) << 2);
      r  = int'($urandom_range(99, 0));
      if (r < 4)       do_flush_idle(a);
      else if (r < 8)  do_access(a, 0, 3, EV_REDIR, int'($urandom_range(LW-1, 0)), ra);
      else if (r < 11) do_access(a, 0, 3, EV_FLUSH, int'($urandom_range(LW-1, 0)), ra);
      else if (r < 13) do_access(a, 0, 3, EV_RST, int'($urandom_range(LW-1, 0)), ra);
      else             do_access(a, 0, 3, EV_NONE, -1, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
